// File: rtl/residual_min_tracker.sv
// residual_min_tracker
// Tracks the smallest non-negative residual sum of a run of NUM_WIN fitted
// windows and the index of its window. It also counts the windows whose
// residual exceeds a threshold that is sampled at start. When the run is
// complete, the result is held and offered to the consumer with a
// valid/ack handshake.
module residual_min_tracker #(
    parameter int RES_W   = 125,
    parameter int NUM_WIN = 8000,
    parameter int IDX_W   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    res_valid,
    input  logic signed [RES_W-1:0] res_in,
    input  logic signed [RES_W-1:0] thr_in,
    output logic                    busy,
    output logic [IDX_W-1:0]        win_cnt,
    output logic signed [RES_W-1:0] min_res,
    output logic [IDX_W-1:0]        min_idx,
    output logic [IDX_W-1:0]        over_cnt,
    output logic                    neg_seen,
    output logic                    overrun,
    output logic                    done_valid,
    input  logic                    done_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Largest positive signed value: the minimum search starts from here.
    localparam logic signed [RES_W-1:0] MAX_POS  = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_WIN - 1);
    localparam logic [IDX_W-1:0]        CNT_MAX  = {IDX_W{1'b1}};

    state_t                    state;
    state_t                    state_nxt;
    logic signed [RES_W-1:0]   thr;

    // Per-sample classification used by the datapath.
    logic is_neg;
    logic below_min;
    logic above_thr;
    logic last_sample;

    assign is_neg      = res_in[RES_W-1];
    assign below_min   = res_in < min_res;
    assign above_thr   = res_in > thr;
    assign last_sample = res_valid && (win_cnt == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start opens a run, the NUM_WIN-th sample closes it, ack releases the hold.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)       state_nxt = S_RUN;
            S_RUN:   if (last_sample) state_nxt = S_HOLD;
            S_HOLD:  if (done_ack)    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: handshake flags follow the state directly.
    always_comb begin
        busy       = 1'b0;
        done_valid = 1'b0;
        case (state)
            S_RUN:   busy       = 1'b1;
            S_HOLD:  done_valid = 1'b1;
            default: ;
        endcase
    end

    // Result datapath: the run is initialised at start and updated once per accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr      <= '0;
            min_res  <= '0;
            min_idx  <= '0;
            win_cnt  <= '0;
            over_cnt <= '0;
            neg_seen <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        thr      <= thr_in;
                        min_res  <= MAX_POS;
                        min_idx  <= '0;
                        win_cnt  <= '0;
                        over_cnt <= '0;
                        neg_seen <= 1'b0;
                        // A residual arriving with start is still outside the run.
                        overrun  <= res_valid;
                    end else if (res_valid) begin
                        overrun <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (res_valid) begin
                        win_cnt <= win_cnt + IDX_W'(1);
                        if (is_neg) begin
                            neg_seen <= 1'b1;
                        end else begin
                            // Strict compare: a tie keeps the earlier window index.
                            if (below_min) begin
                                min_res <= res_in;
                                min_idx <= win_cnt;
                            end
                            if (above_thr && (over_cnt != CNT_MAX)) begin
                                over_cnt <= over_cnt + IDX_W'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (res_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_residual_min_tracker.sv
// Testbench for residual_min_tracker (NUM_WIN overridden to 4).
// The reference model keeps the full list of residuals of the current run
// and recomputes the expected min, index, over count and negative flag from
// that history on every cycle. It then compares all DUT outputs. Directed
// literal checks pin the model to hand-computed values.
module tb_residual_min_tracker;

    localparam int RES_W   = 125;
    localparam int NUM_WIN = 4;
    localparam int IDX_W   = 15;
    localparam logic signed [RES_W-1:0] MAX_POS = {1'b0, {(RES_W-1){1'b1}}};

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    res_valid = 1'b0;
    logic signed [RES_W-1:0] res_in = '0;
    logic signed [RES_W-1:0] thr_in = '0;
    logic                    busy;
    logic [IDX_W-1:0]        win_cnt;
    logic signed [RES_W-1:0] min_res;
    logic [IDX_W-1:0]        min_idx;
    logic [IDX_W-1:0]        over_cnt;
    logic                    neg_seen;
    logic                    overrun;
    logic                    done_valid;
    logic                    done_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    residual_min_tracker #(.RES_W(RES_W), .NUM_WIN(NUM_WIN), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .res_valid  (res_valid),
        .res_in     (res_in),
        .thr_in     (thr_in),
        .busy       (busy),
        .win_cnt    (win_cnt),
        .min_res    (min_res),
        .min_idx    (min_idx),
        .over_cnt   (over_cnt),
        .neg_seen   (neg_seen),
        .overrun    (overrun),
        .done_valid (done_valid),
        .done_ack   (done_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = waiting for start, 1 = collecting, 2 = result offered.
    int                      m_phase = 0;
    bit                      m_init = 0;
    bit                      m_started = 0;
    bit                      m_ovr = 0;
    logic signed [RES_W-1:0] m_thr = '0;
    logic signed [RES_W-1:0] m_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_phase = 0;
            m_started = 0;
            m_ovr = 0;
            m_thr = '0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (start) begin
                        m_started = 1;
                        m_thr = thr_in;
                        m_q.delete();
                        m_ovr = res_valid;
                        m_phase = 1;
                    end else if (res_valid) begin
                        m_ovr = 1;
                    end
                end
                1: begin
                    if (res_valid) begin
                        m_q.push_back(res_in);
                        if (m_q.size() == NUM_WIN) m_phase = 2;
                    end
                end
                default: begin
                    if (res_valid) m_ovr = 1;
                    if (done_ack) m_phase = 0;
                end
            endcase
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            logic signed [RES_W-1:0] e_min;
            int e_idx, e_over, e_win;
            bit e_neg;
            e_min = '0; e_idx = 0; e_over = 0; e_win = 0; e_neg = 0;
            if (m_started) begin
                e_min = MAX_POS;
                e_win = m_q.size();
                for (int i = 0; i < m_q.size(); i++) begin
                    if (m_q[i] < 0) begin
                        e_neg = 1;
                    end else begin
                        if (m_q[i] < e_min) begin
                            e_min = m_q[i];
                            e_idx = i;
                        end
                        if (m_q[i] > m_thr) e_over++;
                    end
                end
            end
            check("busy",       RES_W'(busy),       RES_W'(m_phase == 1));
            check("done_valid", RES_W'(done_valid), RES_W'(m_phase == 2));
            check("win_cnt",    RES_W'(win_cnt),    RES_W'(e_win));
            check("min_res",    min_res,            e_min);
            check("min_idx",    RES_W'(min_idx),    RES_W'(e_idx));
            check("over_cnt",   RES_W'(over_cnt),   RES_W'(e_over));
            check("neg_seen",   RES_W'(neg_seen),   RES_W'(e_neg));
            check("overrun",    RES_W'(overrun),    RES_W'(m_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; res_valid = 0; done_ack = 0; res_in = '0;
    endtask

    task automatic feed(input int v);
        res_valid = 1;
        res_in = v;
        step();
        res_valid = 0;
    endtask

    task automatic do_start(input int t);
        start = 1;
        thr_in = t;
        step();
        start = 0;
    endtask

    function automatic logic signed [RES_W-1:0] rand_res();
        logic [127:0] big;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) begin
            big = {$urandom(), $urandom(), $urandom(), $urandom()};
            return big[RES_W-1:0];
        end
        return RES_W'(int'($urandom_range(0, 300)) - 50);
    endfunction

    initial begin
        // Reset for two cycles.
        step();
        step();
        rst = 0;
        check("rst_busy", RES_W'(busy), '0);
        check("rst_min", min_res, '0);
        check("rst_done", RES_W'(done_valid), '0);

        // Run 1: thr 100, residuals 50,30,30,120.
        do_start(100);
        check("r1_busy", RES_W'(busy), RES_W'(1));
        check("r1_min_init", min_res, MAX_POS);
        feed(50);
        feed(30);
        feed(30);
        check("r1_done_early", RES_W'(done_valid), '0);
        feed(120);
        check("r1_done", RES_W'(done_valid), RES_W'(1));
        check("r1_busy_end", RES_W'(busy), '0);
        check("r1_min", min_res, RES_W'(30));
        check("r1_idx", RES_W'(min_idx), RES_W'(1));
        check("r1_over", RES_W'(over_cnt), RES_W'(1));
        check("r1_win", RES_W'(win_cnt), RES_W'(4));
        // Stray residual and start in HOLD.
        feed(5);
        check("hold_min", min_res, RES_W'(30));
        check("hold_ovr", RES_W'(overrun), RES_W'(1));
        do_start(7);
        check("hold_start_ign", RES_W'(done_valid), RES_W'(1));
        done_ack = 1; step(); done_ack = 0;
        check("ack_done", RES_W'(done_valid), '0);
        check("idle_min", min_res, RES_W'(30));
        step();

        // Run 2: thr 150, 10,-7,200,10 with stray start mid-run and ack on last sample.
        do_start(150);
        feed(10);
        start = 1; feed(-7); start = 0;
        feed(200);
        done_ack = 1; feed(10); done_ack = 0;
        check("r2_done", RES_W'(done_valid), RES_W'(1));
        check("r2_neg", RES_W'(neg_seen), RES_W'(1));
        check("r2_win", RES_W'(win_cnt), RES_W'(4));
        check("r2_min", min_res, RES_W'(10));
        check("r2_idx", RES_W'(min_idx), '0);
        check("r2_over", RES_W'(over_cnt), RES_W'(1));
        check("r2_ovr", RES_W'(overrun), '0);
        done_ack = 1; step(); done_ack = 0;

        // Start coincident with residual, then reset after two samples.
        start = 1; thr_in = 0; res_valid = 1; res_in = 3; step(); idle_inputs();
        check("coinc_ovr", RES_W'(overrun), RES_W'(1));
        check("coinc_win", RES_W'(win_cnt), '0);
        feed(5);
        feed(6);
        rst = 1; step(); rst = 0;
        check("midrst_busy", RES_W'(busy), '0);
        check("midrst_win", RES_W'(win_cnt), '0);
        check("midrst_min", min_res, '0);
        do_start(0);
        feed(7); feed(3); feed(9); feed(3);
        check("r3_min", min_res, RES_W'(3));
        check("r3_idx", RES_W'(min_idx), RES_W'(1));
        check("r3_over", RES_W'(over_cnt), RES_W'(4));
        check("r3_done", RES_W'(done_valid), RES_W'(1));
        done_ack = 1; step(); done_ack = 0;

        // Randomised runs.
        for (int r = 0; r < 40; r++) begin
            start = 1;
            thr_in = RES_W'(int'($urandom_range(0, 250)) - 20);
            res_valid = ($urandom_range(0, 4) == 0);
            res_in = rand_res();
            step();
            idle_inputs();
            for (int k = 0; k < 200 && m_phase == 1; k++) begin
                res_valid = ($urandom_range(0, 9) < 7);
                res_in = rand_res();
                start = ($urandom_range(0, 7) == 0);
                done_ack = ($urandom_range(0, 7) == 0);
                rst = ($urandom_range(0, 199) == 0);
                step();
                idle_inputs();
                rst = 0;
            end
            if (m_phase == 2) begin
                check("rnd_done", RES_W'(done_valid), RES_W'(1));
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    res_valid = ($urandom_range(0, 2) == 0);
                    res_in = rand_res();
                    start = ($urandom_range(0, 2) == 0);
                    step();
                    idle_inputs();
                end
                done_ack = 1;
                res_valid = ($urandom_range(0, 3) == 0);
                step();
                idle_inputs();
            end else if (m_phase == 1) begin
                check("rnd_run_timeout", RES_W'(done_valid), RES_W'(1));
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                res_valid = ($urandom_range(0, 3) == 0);
                done_ack = ($urandom_range(0, 3) == 0);
                res_in = rand_res();
                step();
                idle_inputs();
            end
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/residual_min_tracker.md
Name: residual_min_tracker

Overview:
- Downstream of the least-squares fit/residual stage.
- Consumes one absolute-residual sum per fitted window, with a valid strobe per window.
- Tracks the smallest residual and the index of its window, and counts windows whose residual exceeds a programmable threshold.
- Presents a held result with a valid/ack handshake once NUM_WIN windows have been absorbed.

Parameters:
- RES_W, 125, width of the signed residual sum input, matching the fit stage's sum_final.
- NUM_WIN, 8000, number of windows per run.
- IDX_W, 15, width of window index and counters; must satisfy 2^IDX_W > NUM_WIN.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE only).
- res_valid  in  1  residual strobe, one cycle per window.
- res_in  in  RES_W  signed residual sum; valid when res_valid=1.
- thr_in  in  RES_W  signed threshold; sampled at start.
- busy  out  1  high in RUN.
- win_cnt  out  IDX_W  windows accepted in the current run.
- min_res  out  RES_W  smallest non-negative residual seen.
- min_idx  out  IDX_W  0-based window index of min_res.
- over_cnt  out  IDX_W  windows with res_in > threshold.
- neg_seen  out  1  sticky; a negative res_in was received in RUN.
- overrun  out  1  sticky; res_valid was received outside RUN.
- done_valid  out  1  result valid, held in HOLD.
- done_ack  in  1  consumer acknowledge of the result.

Behaviour:
- Reset applies on the clk edge with rst=1, and overrides everything, including mid-run.
- Reset values: state=IDLE, busy=0, win_cnt=0, min_res=0, min_idx=0, over_cnt=0, neg_seen=0, overrun=0, done_valid=0, internal thr=0.
- States: IDLE, RUN, HOLD.
- IDLE, start=1:
  - thr <= thr_in.
  - min_res <= max positive value (0 followed by all ones).
  - min_idx, win_cnt, over_cnt <= 0.
  - neg_seen, overrun <= 0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=0: all outputs hold their last values, so the previous run's results stay readable.
- RUN, each cycle with res_valid=1:
  - win_cnt <= win_cnt+1.
  - If res_in is negative (sign bit set): neg_seen <= 1; the sample is excluded from the min and threshold checks but still counted in win_cnt.
  - Else if res_in < min_res (strict): min_res <= res_in and min_idx <= current win_cnt (pre-increment value). Ties keep the earlier index.
  - If res_in is non-negative and res_in > thr (strict, signed compare): over_cnt <= over_cnt+1, saturating at all ones.
  - All updates are visible on the cycle after the strobe (latency 1).
- RUN end condition: when the accepted sample is number NUM_WIN (win_cnt == NUM_WIN-1 with res_valid=1), go to HOLD; done_valid=1 and busy=0 on the next cycle.
- start during RUN or HOLD: ignored.
- res_valid in IDLE or HOLD: sample discarded; overrun <= 1; no other change.
- HOLD:
  - done_valid=1; all result outputs stable.
  - done_ack=1: go to IDLE, done_valid=0 next cycle.
  - done_ack in any other state: ignored.
- Simultaneous events:
  - res_valid together with done_ack in HOLD: the ack is honoured and overrun is set.
  - Final res_valid in RUN together with done_ack: the ack is ignored (not in HOLD yet); HOLD is entered.
- Back-to-back res_valid on every cycle is supported; there is no backpressure and the block never stalls the producer.
- Arithmetic: all comparisons are signed RES_W bits; no rounding. Counters are unsigned IDX_W bits.

Test Plan:
- (NUM_WIN=4 override) rst high 2 cycles -> all outputs 0, state IDLE; start with thr_in=100 -> busy=1 the next cycle, min_res=2^(RES_W-1)-1.
- Residuals 50,30,30,120 on 4 consecutive cycles -> min_res=30, min_idx=1 (tie keeps earlier), over_cnt=1, win_cnt=4; done_valid=1 exactly one cycle after the 4th strobe; busy=0.
- In HOLD, pulse res_valid with 5 -> min_res stays 30, overrun=1; done_ack -> done_valid=0 next cycle, results still readable in IDLE.
- Run with residuals 10,-7,200,10 and thr_in=150 -> neg_seen=1, win_cnt=4, min_res=10, min_idx=0, over_cnt=1.
- rst asserted after 2 of 4 samples in RUN -> next cycle all reset values; a new start then completes a full 4-sample run correctly.
- start pulsed mid-RUN and during HOLD -> no effect on counters or state; a start coincident with the 1st residual in IDLE -> residual flagged as overrun, not counted.
